// File: rtl/adda_dac_streamer.sv
// AD9708 transmit path: stream samples from a FIFO or generate sawtooth/triangle/square
// test waveforms, paced by a programmable sample-rate ticker. o_dac_data feeds the DAC directly.
module adda_dac_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic [1:0]                    i_mode,
  input  logic [DIV_WIDTH-1:0]          i_rate_div,
  input  logic [DATA_WIDTH-1:0]         i_s_data,
  input  logic                          i_s_valid,
  output logic                          o_s_ready,
  input  logic                          i_clear_flags,
  output logic [DATA_WIDTH-1:0]         o_dac_data,
  output logic                          o_sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SQR    = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MIDSCALE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] PHASE_MAX = '1;
  localparam logic [LW-1:0]         LVL_FULL  = LW'(FIFO_DEPTH);

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] phase_q, phase_d;
  logic                  up_q, up_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic                  strobe_q, strobe_d;
  logic                  uf_q, uf_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  tick, empty, full, push, pop, uf_set, mode_chg;
  logic [DATA_WIDTH-1:0] ph_base;
  logic                  up_base;

  // Sample-rate ticker; >= compare so a lowered divider takes effect immediately.
  always_comb begin
    tick  = i_enable && (cnt_q >= i_rate_div);
    cnt_d = (!i_enable || tick) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_FULL);
    push     = i_s_valid && !full;
    mode_chg = (i_mode != mode_q);
    mode_d   = i_mode;
    // A mode change restarts the generator; a coincident tick then steps from phase 0.
    ph_base  = mode_chg ? '0   : phase_q;
    up_base  = mode_chg ? 1'b1 : up_q;

    pop      = 1'b0;
    uf_set   = 1'b0;
    dac_d    = dac_q;
    strobe_d = 1'b0;
    phase_d  = ph_base;
    up_d     = up_base;

    if (tick) begin
      case (i_mode)
        MODE_STREAM: begin
          if (!empty) begin
            pop      = 1'b1;
            dac_d    = mem_q[rptr_q];
            strobe_d = 1'b1;
          end else begin
            uf_set   = 1'b1;
          end
        end
        MODE_SAW: begin
          phase_d  = ph_base + 1'b1;
          dac_d    = phase_d;
          strobe_d = 1'b1;
        end
        MODE_TRI: begin
          if (up_base) begin
            if (ph_base == PHASE_MAX) begin
              up_d    = 1'b0;
              phase_d = ph_base - 1'b1;
            end else begin
              phase_d = ph_base + 1'b1;
            end
          end else begin
            if (ph_base == '0) begin
              up_d    = 1'b1;
              phase_d = ph_base + 1'b1;
            end else begin
              phase_d = ph_base - 1'b1;
            end
          end
          dac_d    = phase_d;
          strobe_d = 1'b1;
        end
        default: begin
          phase_d  = ph_base + 1'b1;
          dac_d    = phase_d[DATA_WIDTH-1] ? '1 : '0;
          strobe_d = 1'b1;
        end
      endcase
    end

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    uf_d = uf_set ? 1'b1 : (i_clear_flags ? 1'b0 : uf_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      up_q     <= 1'b1;
      mode_q   <= MODE_STREAM;
      dac_q    <= MIDSCALE;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      up_q     <= up_d;
      mode_q   <= mode_d;
      dac_q    <= dac_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= i_s_data;
  end

  assign o_s_ready       = !full;
  assign o_dac_data      = dac_q;
  assign o_sample_strobe = strobe_q;
  assign o_fifo_level    = level_q;
  assign o_underflow     = uf_q;
endmodule

// File: doc/adda_dac_streamer.md
Name: adda_dac_streamer

Overview:
- Transmit-side counterpart of the ADC capture path on the ULX3S AD/DA board.
- Accepts 8-bit samples over a valid/ready stream into a small FIFO and replays them to the AD9708 DAC port at a programmable sample rate.
- Can instead generate built-in test waveforms (sawtooth, triangle, square) for bench and loopback checks.
- The DAC clock is i_clk itself; o_dac_data drives J2_DA_PORT directly.

Parameters:
- DATA_WIDTH, 8: sample width; must match the DAC port.
- FIFO_DEPTH, 16: FIFO entries; power of two, at least 2.
- DIV_WIDTH, 8: width of the rate divider input.

Ports:
- i_clk  in  1  system clock (25 MHz); also the DAC clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_enable  in  1  1 = run the sample-rate ticker; 0 = freeze the output.
- i_mode  in  2  0 = stream from FIFO, 1 = sawtooth, 2 = triangle, 3 = square.
- i_rate_div  in  DIV_WIDTH  sample period = i_rate_div+1 clocks.
- i_s_data  in  DATA_WIDTH  input sample.
- i_s_valid  in  1  input sample valid.
- o_s_ready  out  1  FIFO can accept a sample.
- i_clear_flags  in  1  clears o_underflow.
- o_dac_data  out  DATA_WIDTH  registered DAC code.
- o_sample_strobe  out  1  one-cycle pulse when o_dac_data updates.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_underflow  out  1  sticky; set when a stream tick finds the FIFO empty.

Behaviour:

Reset (i_reset_n low at a rising edge):
- o_dac_data=8'h80 (midscale), o_sample_strobe=0, o_underflow=0.
- FIFO empty, so o_fifo_level=0 and o_s_ready=1.
- Divider count=0, phase=0, triangle direction=up.

Ticker:
- Runs only while i_enable=1.
- Count increments each clock. When count >= i_rate_div, a tick is generated and count returns to 0.
- Because the compare is >=, lowering i_rate_div below the current count ticks on the next cycle.
- i_rate_div=0 gives a tick every clock (25 MSPS).
- i_enable=0: count held at 0, no ticks, o_dac_data holds its value.

Latency:
- A tick at cycle n updates o_dac_data at n+1, with o_sample_strobe=1 for exactly that cycle.

FIFO:
- Push when i_s_valid && o_s_ready.
- o_s_ready = !full, derived from registered occupancy.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the extra level bit distinguishes full from empty.
- Push and pop in the same cycle leave the level unchanged.
- The FIFO accepts pushes in every mode but pops only on ticks in mode 0.

Mode 0 (stream) tick:
- FIFO non-empty: pop the head into o_dac_data.
- FIFO empty: o_dac_data holds its last value, o_underflow is set, no strobe.
- Push into an empty FIFO on the same cycle as a tick counts as underflow; the pushed sample is output on the following tick.

Mode 1 (sawtooth) tick:
- phase+1, wrapping 255 to 0; o_dac_data=phase.

Mode 2 (triangle) tick:
- Counts up to 255, then down to 0, and repeats.
- The endpoint is emitted once, e.g. ...,254,255,254,... and ...,1,0,1,...
- o_dac_data=phase.

Mode 3 (square) tick:
- Phase advances as in sawtooth.
- o_dac_data = phase[7] ? 8'hFF : 8'h00, i.e. 128 ticks per level.

Mode change:
- Any change of i_mode (compared with the registered previous mode) resets phase=0 and direction=up.
- The divider count is not reset.
- The output holds until the next tick.

Flags:
- o_underflow stays set until i_clear_flags=1.
- If set and clear occur in the same cycle, set wins.

Reset mid-operation:
- Aborts all state to the reset values on that edge; FIFO contents are discarded.

Test Plan:
- Reset, then check outputs: o_dac_data=8'h80, o_fifo_level=0, o_s_ready=1, o_underflow=0, no strobe while i_enable=0.
- Mode 0, i_rate_div=3, push 0x10,0x20,0x30: o_dac_data goes 0x10,0x20,0x30 on strobes spaced exactly 4 clocks apart, each 1 clock after its tick; o_fifo_level steps 3→2→1→0.
- Continue the previous case with no pushes: the next tick sets o_underflow, o_dac_data stays 0x30, no strobe. Assert i_clear_flags: o_underflow returns to 0.
- Fill with 16 pushes while i_enable=0: o_s_ready drops after the 16th, a 17th valid is not accepted, o_fifo_level=16. Enable with i_rate_div=0: all 16 samples come out in push order on consecutive clocks.
- Mode 2, i_rate_div=0: the sequence reaches 255 and the next sample is 254; it reaches 0 and the next is 1; period is 510 ticks.
- Mode 3, i_rate_div=0: output is 0x00 for 128 strobes, then 0xFF for 128. Switch to mode 1 mid-run: the next sample is 0x01.
